// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
package fwd_pkg;

  // Widest register address a slot can hold. Narrower addresses are zero-extended.
  localparam int RD_MAX_W = 8;

  // Forwarding select value meaning "read the register file".
  localparam int FWD_RF = 0;

  // One tracked producer: a valid writer of rd, and whether it is a load.
  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                is_load;
  } slot_t;

  // Width of a select field that encodes 0 (register file) through depth.
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_match_arb.sv
// Priority lookup of one source operand against all tracked producer slots.
// slots[0] is slot 1 (EX, youngest); slots[DEPTH-1] is the oldest slot.
module fwd_match_arb
  import fwd_pkg::*;
#(
  parameter int AW       = 3,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int SELW     = 2
) (
  input  slot_t [DEPTH-1:0] slots,
  input  logic [AW-1:0]     src_addr,
  input  logic              src_used,
  output logic [SELW-1:0]   win_idx,
  output logic              found,
  output logic              not_ready
);

  // Scan oldest to youngest so the youngest match overwrites any older one;
  // readiness is judged only on that winner, never on an older fallback.
  always_comb begin
    win_idx   = SELW'(FWD_RF);
    found     = 1'b0;
    not_ready = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (src_used && slots[k].valid && (slots[k].rd == RD_MAX_W'(src_addr))) begin
        win_idx   = SELW'(k + 1);
        found     = 1'b1;
        not_ready = slots[k].is_load && ((k + 1) < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Multi-operand forwarding select and load-use stall detection over DEPTH
// in-flight producer slots, with a saturating stall-cycle counter.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter  int AW       = 3,
  parameter  int NUM_SRC  = 2,
  parameter  int DEPTH    = 3,
  parameter  int LOAD_LAT = 2,
  parameter  int CNT_W    = 16,
  localparam int SELW     = sel_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_rd,
  input  logic                    issue_regwrite,
  input  logic                    issue_is_load,
  input  logic                    flush,
  input  logic [NUM_SRC*AW-1:0]   src_addr,
  input  logic [NUM_SRC-1:0]      src_used,
  output logic [NUM_SRC*SELW-1:0] fwd_sel,
  output logic                    stall,
  output logic [CNT_W-1:0]        stall_cnt
);

  slot_t [DEPTH-1:0]       slot_q;
  slot_t                   issue_slot;
  logic [NUM_SRC*SELW-1:0] win_sel;
  logic [NUM_SRC-1:0]      found;
  logic [NUM_SRC-1:0]      stall_req;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match_arb #(
      .AW       (AW),
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .SELW     (SELW)
    ) u_arb (
      .slots     (slot_q),
      .src_addr  (src_addr[i*AW +: AW]),
      .src_used  (src_used[i]),
      .win_idx   (win_sel[i*SELW +: SELW]),
      .found     (found[i]),
      .not_ready (stall_req[i])
    );
  end

  assign stall = |stall_req;

  // Entry entering slot 1: the decode instruction, or a bubble when it is held.
  always_comb begin
    issue_slot = '0;
    if (issue_valid && !stall) begin
      issue_slot.valid   = issue_regwrite;
      issue_slot.rd      = RD_MAX_W'(issue_rd);
      issue_slot.is_load = issue_is_load;
    end
  end

  // Forwarding selects; all fields drop to the register file while stalled.
  always_comb begin
    fwd_sel = '0;
    if (!stall) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        fwd_sel[i*SELW +: SELW] = found[i] ? win_sel[i*SELW +: SELW] : SELW'(FWD_RF);
      end
    end
  end

  // Producer shift register; older slots keep draining while decode is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (flush) begin
      slot_q <= '0;
    end else begin
      slot_q[0] <= issue_slot;
      for (int k = 1; k < DEPTH; k++) begin
        slot_q[k] <= slot_q[k-1];
      end
    end
  end

  // Saturating count of stalled cycles; flush does not affect it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: a default-parameter instance and a
// CNT_W=4 instance sharing stimulus, the latter used for counter saturation.
module tb_fwd_hazard_unit;
  import fwd_pkg::*;

  localparam int AW      = 3;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 3;
  localparam int SELW    = sel_width(DEPTH);

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    rst_n_sat;
  logic                    issue_valid;
  logic [AW-1:0]           issue_rd;
  logic                    issue_regwrite;
  logic                    issue_is_load;
  logic                    flush;
  logic [NUM_SRC*AW-1:0]   src_addr;
  logic [NUM_SRC-1:0]      src_used;
  logic [NUM_SRC*SELW-1:0] fwd_sel;
  logic                    stall;
  logic [15:0]             stall_cnt;
  logic [NUM_SRC*SELW-1:0] fwd_sel_sat;
  logic                    stall_sat;
  logic [3:0]              stall_cnt_sat;

  typedef struct {
    string tag;
    int    sel0;
    int    sel1;
    bit    stl;
    int    cnt;
    bit    chk_sat;
    int    cnt_sat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_regwrite (issue_regwrite),
    .issue_is_load  (issue_is_load),
    .flush          (flush),
    .src_addr       (src_addr),
    .src_used       (src_used),
    .fwd_sel        (fwd_sel),
    .stall          (stall),
    .stall_cnt      (stall_cnt)
  );

  fwd_hazard_unit #(.CNT_W(4)) dut_sat (
    .clk            (clk),
    .rst_n          (rst_n_sat),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_regwrite (issue_regwrite),
    .issue_is_load  (issue_is_load),
    .flush          (flush),
    .src_addr       (src_addr),
    .src_used       (src_used),
    .fwd_sel        (fwd_sel_sat),
    .stall          (stall_sat),
    .stall_cnt      (stall_cnt_sat)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_compare();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty: observed 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    check({e.tag, "/sel0"}, int'(fwd_sel[0 +: SELW]), e.sel0);
    check({e.tag, "/sel1"}, int'(fwd_sel[SELW +: SELW]), e.sel1);
    check({e.tag, "/stall"}, int'(stall), int'(e.stl));
    check({e.tag, "/cnt"}, int'(stall_cnt), e.cnt);
    if (e.chk_sat) begin
      check({e.tag, "/sat_sel0"}, int'(fwd_sel_sat[0 +: SELW]), e.sel0);
      check({e.tag, "/sat_stall"}, int'(stall_sat), int'(e.stl));
      check({e.tag, "/sat_cnt"}, int'(stall_cnt_sat), e.cnt_sat);
    end
  endtask

  task automatic drive(input bit iv, input int rd, input bit rw, input bit ld,
                       input bit fl, input int s0, input int s1, input bit [1:0] used);
    issue_valid    = iv;
    issue_rd       = AW'(rd);
    issue_regwrite = rw;
    issue_is_load  = ld;
    flush          = fl;
    src_addr       = {AW'(s1), AW'(s0)};
    src_used       = used;
  endtask

  task automatic push(input string tag, input int e0, input int e1, input bit es,
                      input bit chk_sat, input int cnt_sat);
    exp_t e;
    e.tag     = tag;
    e.sel0    = e0;
    e.sel1    = e1;
    e.stl     = es;
    e.cnt     = exp_cnt;
    e.chk_sat = chk_sat;
    e.cnt_sat = cnt_sat;
    sb.push_back(e);
  endtask

  // Compare at the falling edge, account for the stall edge, land just after the rising edge.
  task automatic tick();
    bit stl_e;
    @(negedge clk);
    stl_e = (sb.size() > 0) ? sb[0].stl : 1'b0;
    sb_compare();
    if (stl_e) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input bit iv, input int rd, input bit rw,
                      input bit ld, input bit fl, input int s0, input int s1,
                      input bit [1:0] used, input int e0, input int e1, input bit es);
    drive(iv, rd, rw, ld, fl, s0, s1, used);
    push(tag, e0, e1, es, 1'b0, 0);
    tick();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step("idle", 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    rst_n_sat = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00);

    // Reset state: issue and lookups are ignored while reset is held.
    step("rst_hold", 1, 3, 1, 0, 0, 3, 3, 2'b11, 0, 0, 0);
    rst_n = 1'b1;
    step("post_rst", 0, 0, 0, 0, 0, 3, 3, 2'b11, 0, 0, 0);

    // ALU forward through every slot, then retire.
    step("alu_iss", 1, 3, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    step("alu_s1",  0, 0, 0, 0, 0, 3, 0, 2'b01, 1, 0, 0);
    step("alu_s2",  0, 0, 0, 0, 0, 3, 0, 2'b01, 2, 0, 0);
    step("alu_s3",  0, 0, 0, 0, 0, 3, 0, 2'b01, 3, 0, 0);
    step("retire",  0, 0, 0, 0, 0, 3, 0, 2'b01, 0, 0, 0);

    // Load-use: one stall cycle, then forward from slot 2.
    step("ld_iss",   1, 5, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0);
    step("ld_stall", 1, 6, 1, 0, 0, 0, 5, 2'b10, 0, 0, 1);
    step("ld_fwd",   1, 6, 1, 0, 0, 0, 5, 2'b10, 0, 2, 0);
    idle(3);

    // Youngest writer wins; a young load stalls with no fallback.
    step("yw_a",   1, 2, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    step("yw_b",   1, 2, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    step("yw_alu", 0, 0, 0, 0, 0, 2, 2, 2'b11, 1, 1, 0);
    idle(3);
    step("yw_c",   1, 2, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    step("yw_d",   1, 2, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0);
    step("yw_ld",  0, 0, 0, 0, 0, 2, 2, 2'b11, 0, 0, 1);
    step("yw_ld2", 0, 0, 0, 0, 0, 2, 2, 2'b11, 2, 2, 0);
    idle(3);

    // No writer, unused operand, and r0 forwarding like any register.
    step("nw_iss",     1, 4, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    step("nw_chk",     0, 0, 0, 0, 0, 4, 0, 2'b01, 0, 0, 0);
    step("unused_iss", 1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    step("unused_chk", 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0);
    step("used_chk",   0, 0, 0, 0, 0, 1, 1, 2'b10, 0, 2, 0);
    step("r0_iss",     1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    step("r0_chk",     0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0);
    idle(3);

    // Flush: full pipe, flush overrides the concurrent issue.
    step("fl_a",    1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    step("fl_b",    1, 2, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    step("fl_c",    1, 3, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    step("fl_pre",  1, 4, 1, 0, 1, 1, 3, 2'b11, 3, 1, 0);
    step("fl_post", 0, 0, 0, 0, 0, 4, 3, 2'b11, 0, 0, 0);

    // Asynchronous reset in the middle of a load-use stall.
    step("rs_iss", 1, 5, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 5, 0, 2'b01);
    push("rs_stall", 0, 0, 1, 1'b0, 0);
    @(negedge clk);
    sb_compare();
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    push("rs_async", 0, 0, 0, 1'b0, 0);
    sb_compare();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rs_after", 0, 0, 0, 0, 0, 5, 0, 2'b01, 0, 0, 0);

    // Saturation: back-to-back dependent loads stall every other cycle.
    rst_n_sat = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive(1, 5, 1, 1, 0, 5, 0, 2'b01);
      push("sat", ((i % 2) == 1 || i == 0) ? 0 : 2, 0, (i % 2) == 1, 1'b1,
           ((i / 2) > 15) ? 15 : (i / 2));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00);
    push("sat_end", 0, 0, 0, 1'b1, 15);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
